sdspi_run_sequencer: RTL and testbench
======================================

Name: sdspi_run_sequencer

Overview:
- Sequences one measured run of the sdspi_system UUT for the autotest module.
- Sequence: latch run config, hand the SD pins to the UUT, pulse UUT reset, assert start, count clock cycles until finish or timeout, return the pins to the autotest side.
- Drives the sdspi_* control/parameter signals and the pin-mux select. Reports cycle count and status to the autotest/debug path.

Parameters:
- RST_CYCLES, 16, cycles sdspi_rst is held high per run (≥1)
- SETTLE_CYCLES, 4, guard cycles after each mux switch (≥1)
- TIMEOUT_CYCLES, 32'hFFFF_FFFE, cycle budget in WAIT_FINISH before abort
- CNT_W, 32, width of the cycle counter

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- run  in  1  one-cycle request to start a run; ignored unless idle
- abort  in  1  level; forces orderly termination of a run
- cfg_n_blocks  in  32  number of blocks to transfer
- cfg_sclk_speed  in  5  SCLK divider select
- cfg_cmd18  in  1  1 = multi-block read (CMD18), 0 = single-block reads
- sdspi_finish  in  1  UUT completion level
- sdspi_ctrl_mux  out  1  0 = autotest drives SD pins, 1 = UUT drives them
- sdspi_rst  out  1  UUT reset, active-high
- sdspi_start  out  1  UUT start level
- sdspi_n_blocks  out  32  latched cfg_n_blocks
- sdspi_sclk_speed  out  5  latched cfg_sclk_speed
- sdspi_cmd18  out  1  latched cfg_cmd18
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when a run ends (all outcomes)
- timed_out  out  1  sticky; run ended by timeout
- aborted  out  1  sticky; run ended by abort
- cycles  out  CNT_W  cycles from start assertion to finish; holds its value until the next run

Behaviour:
- Reset values:
  - ctrl_mux=0, sdspi_rst=1, start=0, params=0, busy=0, done=0, timed_out=0, aborted=0, cycles=0, state=IDLE.
  - While in IDLE, the UUT is held in reset.
- IDLE:
  - On run=1: latch the cfg_* inputs into the sdspi_* outputs, clear timed_out, aborted and cycles, then go to HANDOVER.
  - Config is constant for the whole run; cfg changes during a run are ignored.
- HANDOVER: ctrl_mux=1, sdspi_rst=1. Wait SETTLE_CYCLES, then go to RESET_UUT.
- RESET_UUT: sdspi_rst=1 for RST_CYCLES cycles. On the next cycle sdspi_rst=0 and the state goes to ARM.
- ARM:
  - One cycle with sdspi_rst=0 and start=0.
  - If sdspi_finish=1 here (stale), stay in ARM until it falls.
  - Otherwise go to WAIT_FINISH.
- WAIT_FINISH:
  - start=1, held at level.
  - cycles increments by 1 each cycle, starting at 1 in the first cycle start is high.
  - If sdspi_finish=1: freeze cycles (the finish cycle is not counted), go to RELEASE.
  - Else if cycles==TIMEOUT_CYCLES: set timed_out, go to RELEASE.
  - The counter saturates and never wraps.
- RELEASE:
  - start=0, sdspi_rst=1 on entry.
  - Wait SETTLE_CYCLES, then ctrl_mux=0 and go to RETURN.
- RETURN: wait SETTLE_CYCLES with the mux at 0, then pulse done, go to IDLE.
- abort=1 in HANDOVER, RESET_UUT, ARM or WAIT_FINISH:
  - Set aborted and go to RELEASE next cycle.
  - cycles freezes.
  - abort has priority over finish and timeout in the same cycle.
  - abort in RELEASE, RETURN or IDLE has no effect.
- Simultaneous events:
  - run while busy: ignored.
  - finish and the timeout count in the same cycle: finish wins, timed_out stays 0.
- Mux safety:
  - ctrl_mux changes only while sdspi_rst=1 and start=0.
  - Every mux edge is followed by at least SETTLE_CYCLES guard cycles.
- rst_n asserted mid-run: all outputs return to their reset values immediately. The pins return to autotest asynchronously.

Decomposition:
- Shared package sdspi_seq_pkg holds:
  - the state encoding (IDLE, HANDOVER, RESET_UUT, ARM, WAIT_FINISH, RELEASE, RETURN), 3 bits;
  - the mux select constants MUX_AUTOTEST=0 and MUX_UUT=1.
- One sub-module, seq_delay_counter: loadable down-counter with a zero flag. It is shared by the HANDOVER, RESET_UUT, RELEASE and RETURN waits.
- The cycle counter stays inline.

Test Plan:
- Nominal run: cfg_n_blocks=8, speed=3, cmd18=1; run pulse; model asserts finish 500 cycles after start rises.
  - Params latch to 8/3/1.
  - ctrl_mux rises before sdspi_rst falls.
  - cycles=500, done pulses once, timed_out=0.
  - ctrl_mux=0 before done.
- Timeout: TIMEOUT_CYCLES=100, finish never asserted → cycles=100, timed_out=1, start drops, mux returns to 0, done pulses.
- Abort: abort raised 20 cycles into WAIT_FINISH with finish raised the same cycle → aborted=1, timed_out=0, cycles=20, no further increments.
- Stale finish: sdspi_finish held at 1 through RESET_UUT, released 7 cycles after ARM entry → start stays 0 until finish falls, cycles begins at 1 after that.
- Config isolation and run ignored while busy: change cfg_* to 0 and pulse run during WAIT_FINISH → outputs unchanged, only one done pulse.
- Async reset mid-run: drop rst_n during WAIT_FINISH, no clock edge → ctrl_mux=0, sdspi_rst=1, start=0, busy=0 immediately.

Source files
------------

// File: rtl/sdspi_seq_pkg.sv
// rtl/sdspi_seq_pkg.sv - shared types and constants for the SD-SPI run sequencer
//
// Contents:
//   seq_state_e     - 3-bit sequencer state encoding
//   MUX_AUTOTEST    - pin-mux select value giving the SD pins to the autotest side
//   MUX_UUT         - pin-mux select value giving the SD pins to the UUT
//   delay_width()   - bit width able to hold the largest guard/reset delay load
package sdspi_seq_pkg;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        HANDOVER    = 3'd1,
        RESET_UUT   = 3'd2,
        ARM         = 3'd3,
        WAIT_FINISH = 3'd4,
        RELEASE     = 3'd5,
        RETURN      = 3'd6
    } seq_state_e;

    localparam logic MUX_AUTOTEST = 1'b0;
    localparam logic MUX_UUT      = 1'b1;

    // Smallest width (at least 1) that can represent max(a, b).
    function automatic int unsigned delay_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        int unsigned w;
        m = (a > b) ? a : b;
        w = 1;
        while ((m >> w) != 0) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/sdspi_run_sequencer_if.sv
// rtl/sdspi_run_sequencer_if.sv - sequencer-to-UUT control bundle
//
// Signals:
//   sdspi_ctrl_mux    pin-mux select (0 = autotest, 1 = UUT)
//   sdspi_rst         UUT reset, active-high
//   sdspi_start       UUT start level
//   sdspi_n_blocks    run parameter: number of blocks
//   sdspi_sclk_speed  run parameter: SCLK divider select
//   sdspi_cmd18       run parameter: 1 = multi-block read
//   sdspi_finish      UUT completion level (returned to the sequencer)
// Modports:
//   master - the sequencer (drives control/params, observes finish)
//   slave  - the UUT side (observes control/params, drives finish)
interface sdspi_run_sequencer_if;

    logic        sdspi_ctrl_mux;
    logic        sdspi_rst;
    logic        sdspi_start;
    logic [31:0] sdspi_n_blocks;
    logic [4:0]  sdspi_sclk_speed;
    logic        sdspi_cmd18;
    logic        sdspi_finish;

    modport master (
        output sdspi_ctrl_mux,
        output sdspi_rst,
        output sdspi_start,
        output sdspi_n_blocks,
        output sdspi_sclk_speed,
        output sdspi_cmd18,
        input  sdspi_finish
    );

    modport slave (
        input  sdspi_ctrl_mux,
        input  sdspi_rst,
        input  sdspi_start,
        input  sdspi_n_blocks,
        input  sdspi_sclk_speed,
        input  sdspi_cmd18,
        output sdspi_finish
    );

endinterface

// File: rtl/sdspi_run_sequencer_delay.sv
// rtl/sdspi_run_sequencer_delay.sv - loadable down-counter with zero flag
//
// Module seq_delay_counter. One instance times every fixed-length wait of the
// sequencer: load a value of N-1 on state entry and the zero flag marks the
// N-th cycle in that state.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   load        load load_val this cycle (takes priority over counting)
//   load_val    value to load
//   zero        high while the count is zero; the count holds at zero
module seq_delay_counter #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/sdspi_run_sequencer.sv
// rtl/sdspi_run_sequencer.sv - sequences one measured run of the SD-SPI UUT
//
// A run: latch config, hand the SD pins to the UUT, hold UUT reset, raise start,
// count cycles until finish / timeout / abort, then return the pins to autotest.
// Ports:
//   clk, rst_n       clock and asynchronous active-low reset
//   run              one-cycle run request, honoured only in IDLE
//   abort            level; ends an active run in orderly fashion
//   cfg_*            run configuration, sampled on the accepted run request
//   sd               UUT control bundle (master side)
//   busy             high in every state except IDLE
//   done             one-cycle pulse when a run has fully ended
//   timed_out        sticky: last run ended by the cycle budget
//   aborted          sticky: last run ended by abort
//   cycles           start-high cycles counted before the run ended
module sdspi_run_sequencer
    import sdspi_seq_pkg::*;
#(
    parameter int unsigned RST_CYCLES     = 16,
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'hFFFF_FFFE,
    parameter int unsigned CNT_W          = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              abort,
    input  logic [31:0]       cfg_n_blocks,
    input  logic [4:0]        cfg_sclk_speed,
    input  logic              cfg_cmd18,
    sdspi_run_sequencer_if.master sd,
    output logic              busy,
    output logic              done,
    output logic              timed_out,
    output logic              aborted,
    output logic [CNT_W-1:0]  cycles
);

    localparam int unsigned      DLY_W     = delay_width(RST_CYCLES, SETTLE_CYCLES);
    localparam logic [DLY_W-1:0] SETTLE_LD = DLY_W'(SETTLE_CYCLES - 1);
    localparam logic [DLY_W-1:0] RST_LD    = DLY_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    seq_state_e state_q, state_d;

    logic [31:0]      n_blocks_q, n_blocks_d;
    logic [4:0]       sclk_speed_q, sclk_speed_d;
    logic             cmd18_q, cmd18_d;
    logic [CNT_W-1:0] cycles_q, cycles_d;
    logic             timed_out_q, timed_out_d;
    logic             aborted_q, aborted_d;
    logic             done_q, done_d;

    logic             dly_load;
    logic [DLY_W-1:0] dly_val;
    logic             dly_zero;

    logic             abort_hit;
    logic             at_limit;
    logic             mux_o, rst_o, start_o;

    // Abort only acts while the UUT owns the pins and has not yet been released.
    assign abort_hit = abort && ((state_q == HANDOVER) || (state_q == RESET_UUT) ||
                                 (state_q == ARM)      || (state_q == WAIT_FINISH));
    assign at_limit  = (cycles_q == TIMEOUT_C);

    // Every state change reloads the shared delay counter; only the RESET_UUT
    // wait uses the reset length, all mux guard waits use the settle length.
    assign dly_load = (state_d != state_q);
    assign dly_val  = (state_d == RESET_UUT) ? RST_LD : SETTLE_LD;

    seq_delay_counter #(
        .W (DLY_W)
    ) u_delay (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (dly_load),
        .load_val (dly_val),
        .zero     (dly_zero)
    );

    // ---- state register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---- next-state logic ----
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (run) state_d = HANDOVER;
            end
            HANDOVER: begin
                if (abort_hit)     state_d = RELEASE;
                else if (dly_zero) state_d = RESET_UUT;
            end
            RESET_UUT: begin
                if (abort_hit)     state_d = RELEASE;
                else if (dly_zero) state_d = ARM;
            end
            ARM: begin
                // A finish level left over from a previous run must drop first.
                if (abort_hit)              state_d = RELEASE;
                else if (!sd.sdspi_finish)  state_d = WAIT_FINISH;
            end
            WAIT_FINISH: begin
                if (abort_hit || sd.sdspi_finish || at_limit) state_d = RELEASE;
            end
            RELEASE: begin
                if (dly_zero) state_d = RETURN;
            end
            RETURN: begin
                if (dly_zero) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ---- output logic (decoded from state so reset releases the pins at once) ----
    always_comb begin
        mux_o   = MUX_AUTOTEST;
        rst_o   = 1'b1;
        start_o = 1'b0;
        case (state_q)
            HANDOVER, RESET_UUT, RELEASE: begin
                mux_o = MUX_UUT;
            end
            ARM: begin
                mux_o = MUX_UUT;
                rst_o = 1'b0;
            end
            WAIT_FINISH: begin
                mux_o   = MUX_UUT;
                rst_o   = 1'b0;
                start_o = 1'b1;
            end
            default: ;
        endcase
    end

    // ---- run data path: latched config, cycle counter, status flags ----
    always_comb begin
        n_blocks_d   = n_blocks_q;
        sclk_speed_d = sclk_speed_q;
        cmd18_d      = cmd18_q;
        cycles_d     = cycles_q;
        timed_out_d  = timed_out_q;
        aborted_d    = aborted_q;
        done_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (run) begin
                    n_blocks_d   = cfg_n_blocks;
                    sclk_speed_d = cfg_sclk_speed;
                    cmd18_d      = cfg_cmd18;
                    cycles_d     = '0;
                    timed_out_d  = 1'b0;
                    aborted_d    = 1'b0;
                end
            end
            WAIT_FINISH: begin
                // A cycle that ends the run (abort or finish) is not counted;
                // finish outranks the budget check in the same cycle.
                if (!abort && !sd.sdspi_finish) begin
                    if (at_limit) begin
                        timed_out_d = 1'b1;
                    end else if (cycles_q != CNT_MAX) begin
                        cycles_d = cycles_q + CNT_W'(1);
                    end
                end
            end
            RETURN: begin
                done_d = dly_zero;
            end
            default: ;
        endcase
        if (abort_hit) aborted_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_blocks_q   <= '0;
            sclk_speed_q <= '0;
            cmd18_q      <= 1'b0;
            cycles_q     <= '0;
            timed_out_q  <= 1'b0;
            aborted_q    <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            n_blocks_q   <= n_blocks_d;
            sclk_speed_q <= sclk_speed_d;
            cmd18_q      <= cmd18_d;
            cycles_q     <= cycles_d;
            timed_out_q  <= timed_out_d;
            aborted_q    <= aborted_d;
            done_q       <= done_d;
        end
    end

    assign sd.sdspi_ctrl_mux   = mux_o;
    assign sd.sdspi_rst        = rst_o;
    assign sd.sdspi_start      = start_o;
    assign sd.sdspi_n_blocks   = n_blocks_q;
    assign sd.sdspi_sclk_speed = sclk_speed_q;
    assign sd.sdspi_cmd18      = cmd18_q;

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign timed_out = timed_out_q;
    assign aborted   = aborted_q;
    assign cycles    = cycles_q;

endmodule

// File: tb/tb_sdspi_run_sequencer.sv
// tb/tb_sdspi_run_sequencer.sv - scoreboard bench for sdspi_run_sequencer
module tb_sdspi_run_sequencer;

    localparam int RST_C = 16;
    localparam int SET_C = 4;
    localparam int TMO   = 600;
    localparam int NEVER = 32'h7fff_ffff;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] cfg_n_blocks = '0;
    logic [4:0]  cfg_sclk_speed = '0;
    logic        cfg_cmd18 = 1'b0;
    logic        busy, done, timed_out, aborted;
    logic [31:0] cycles;

    sdspi_run_sequencer_if sd_if ();

    sdspi_run_sequencer #(
        .RST_CYCLES     (RST_C),
        .SETTLE_CYCLES  (SET_C),
        .TIMEOUT_CYCLES (32'(TMO)),
        .CNT_W          (32)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .run            (run),
        .abort          (abort),
        .cfg_n_blocks   (cfg_n_blocks),
        .cfg_sclk_speed (cfg_sclk_speed),
        .cfg_cmd18      (cfg_cmd18),
        .sd             (sd_if),
        .busy           (busy),
        .done           (done),
        .timed_out      (timed_out),
        .aborted        (aborted),
        .cycles         (cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] cyc;
        logic        to;
        logic        ab;
        logic [31:0] nb;
        logic [4:0]  sp;
        logic        c18;
    } exp_t;

    exp_t sb_q[$];
    exp_t e;
    int   n_vec = 0;
    int   n_bad = 0;
    int   n_done = 0;
    int   n_pushed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference outcome. Events are expressed as "k start-high cycles elapsed":
    // finish after d, abort after a, budget exhausted after TMO. The earliest
    // ends the run and the count equals its k; ties go abort > finish > timeout.
    function automatic exp_t model(input int d, input int a, input logic [31:0] nb,
                                   input logic [4:0] sp, input logic c18);
        exp_t r;
        int   m;
        m = TMO;
        if (d < m) m = d;
        if (a < m) m = a;
        r.cyc = 32'(m);
        r.to  = (TMO < d) && (TMO < a);
        r.ab  = (a <= d) && (a <= TMO);
        r.nb  = nb;
        r.sp  = sp;
        r.c18 = c18;
        return r;
    endfunction

    // ---- monitor: scoreboard pop on done, plus continuous mux-safety checks ----
    logic prev_mux = 1'b0;
    logic prev_rst = 1'b1;
    int   since_mux = 100;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_mux  = sd_if.sdspi_ctrl_mux;
            prev_rst  = sd_if.sdspi_rst;
            since_mux = 100;
        end else begin
            if (sd_if.sdspi_ctrl_mux != prev_mux) begin
                chk("mux_edge_rst", 32'(sd_if.sdspi_rst), 1);
                chk("mux_edge_start", 32'(sd_if.sdspi_start), 0);
                chk("mux_guard", 32'(since_mux >= SET_C), 1);
                since_mux = 0;
            end else begin
                since_mux++;
            end
            if (prev_rst && !sd_if.sdspi_rst) begin
                chk("rst_fall_mux", 32'(sd_if.sdspi_ctrl_mux), 1);
                chk("rst_fall_guard", 32'(since_mux >= SET_C), 1);
            end
            if (done) begin
                n_done++;
                chk("done_busy", 32'(busy), 0);
                chk("done_mux", 32'(sd_if.sdspi_ctrl_mux), 0);
                if (sb_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL done_unexpected: done pulse with no run pending, expected none");
                end else begin
                    e = sb_q.pop_front();
                    chk("cycles", cycles, e.cyc);
                    chk("timed_out", 32'(timed_out), 32'(e.to));
                    chk("aborted", 32'(aborted), 32'(e.ab));
                    chk("n_blocks", sd_if.sdspi_n_blocks, e.nb);
                    chk("sclk_speed", 32'(sd_if.sdspi_sclk_speed), 32'(e.sp));
                    chk("cmd18", 32'(sd_if.sdspi_cmd18), 32'(e.c18));
                end
            end
            prev_mux = sd_if.sdspi_ctrl_mux;
            prev_rst = sd_if.sdspi_rst;
        end
    end

    task automatic pulse_run(input logic [31:0] nb, input logic [4:0] sp, input logic c18);
        @(negedge clk);
        cfg_n_blocks   = nb;
        cfg_sclk_speed = sp;
        cfg_cmd18      = c18;
        run            = 1'b1;
        @(negedge clk);
        run = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 80; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        chk("end_idle", 32'(busy), 0);
        sd_if.sdspi_finish = 1'b0;
        abort = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // One run: UUT model raises finish after d start-high cycles, abort after a.
    task automatic do_run(input logic [31:0] nb, input logic [4:0] sp, input logic c18,
                          input int d, input int a, input bit stale, input bit poke);
        if (stale) sd_if.sdspi_finish = 1'b1;
        sb_q.push_back(model(d, a, nb, sp, c18));
        n_pushed++;
        pulse_run(nb, sp, c18);
        if (stale) begin
            for (int i = 0; i < 100; i++) begin
                if (!sd_if.sdspi_rst) break;
                @(negedge clk);
            end
            chk("stale_arm_reached", 32'(sd_if.sdspi_rst), 0);
            for (int i = 0; i < 7; i++) begin
                chk("stale_start_low", 32'(sd_if.sdspi_start), 0);
                @(negedge clk);
            end
            sd_if.sdspi_finish = 1'b0;
        end
        for (int i = 0; i < 200; i++) begin
            if (sd_if.sdspi_start) break;
            @(negedge clk);
        end
        chk("start_rise", 32'(sd_if.sdspi_start), 1);
        for (int k = 0; k <= TMO + 5; k++) begin
            if (!sd_if.sdspi_start) break;
            if (k == 1) chk("cycles_first", cycles, 1);
            if (poke && k == 100) begin
                cfg_n_blocks   = '0;
                cfg_sclk_speed = '0;
                cfg_cmd18      = 1'b0;
                run            = 1'b1;
            end
            if (poke && k == 101) begin
                run = 1'b0;
                chk("iso_n_blocks", sd_if.sdspi_n_blocks, nb);
                chk("iso_speed", 32'(sd_if.sdspi_sclk_speed), 32'(sp));
                chk("iso_cmd18", 32'(sd_if.sdspi_cmd18), 32'(c18));
            end
            sd_if.sdspi_finish = (k >= d);
            abort              = (k >= a);
            @(negedge clk);
        end
        chk("start_fall", 32'(sd_if.sdspi_start), 0);
        wait_idle();
    endtask

    task automatic early_abort(input logic [31:0] nb, input logic [4:0] sp, input logic c18);
        logic saw_start;
        exp_t r;
        saw_start = 1'b0;
        r.cyc = 0; r.to = 1'b0; r.ab = 1'b1; r.nb = nb; r.sp = sp; r.c18 = c18;
        sb_q.push_back(r);
        n_pushed++;
        pulse_run(nb, sp, c18);
        repeat (10) @(negedge clk);
        abort = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (sd_if.sdspi_start) saw_start = 1'b1;
            if (!busy) break;
            @(negedge clk);
        end
        chk("early_abort_no_start", 32'(saw_start), 0);
        wait_idle();
    endtask

    initial begin
        sd_if.sdspi_finish = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mux", 32'(sd_if.sdspi_ctrl_mux), 0);
        chk("rst_uut_rst", 32'(sd_if.sdspi_rst), 1);
        chk("rst_start", 32'(sd_if.sdspi_start), 0);
        chk("rst_n_blocks", sd_if.sdspi_n_blocks, 0);
        chk("rst_speed", 32'(sd_if.sdspi_sclk_speed), 0);
        chk("rst_cmd18", 32'(sd_if.sdspi_cmd18), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_timed_out", 32'(timed_out), 0);
        chk("rst_aborted", 32'(aborted), 0);
        chk("rst_cycles", cycles, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        do_run(32'd8, 5'd3, 1'b1, 500, NEVER, 1'b0, 1'b1);        // nominal + config isolation
        do_run(32'h1234, 5'd17, 1'b0, NEVER, NEVER, 1'b0, 1'b0);  // timeout
        do_run(32'd99, 5'd1, 1'b1, 20, 20, 1'b0, 1'b0);           // abort beats finish
        do_run(32'd5, 5'd2, 1'b0, TMO, NEVER, 1'b0, 1'b0);        // finish beats timeout
        do_run(32'd6, 5'd4, 1'b1, NEVER, TMO, 1'b0, 1'b0);        // abort beats timeout
        do_run(32'd7, 5'd9, 1'b0, 0, NEVER, 1'b0, 1'b0);          // finish in first cycle
        do_run(32'd3, 5'd31, 1'b1, 30, NEVER, 1'b1, 1'b0);        // stale finish in ARM
        early_abort(32'd42, 5'd12, 1'b1);

        for (int n = 0; n < 8; n++) begin
            int d, a;
            d = int'($urandom_range(0, TMO + 50));
            a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TMO)) : NEVER;
            do_run($urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), d, a, 1'b0, 1'b0);
        end

        // Asynchronous reset in the middle of WAIT_FINISH, checked between edges.
        pulse_run(32'd77, 5'd6, 1'b1);
        for (int i = 0; i < 200; i++) begin
            if (sd_if.sdspi_start) break;
            @(negedge clk);
        end
        chk("async_start_rise", 32'(sd_if.sdspi_start), 1);
        repeat (10) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("async_mux", 32'(sd_if.sdspi_ctrl_mux), 0);
        chk("async_uut_rst", 32'(sd_if.sdspi_rst), 1);
        chk("async_start", 32'(sd_if.sdspi_start), 0);
        chk("async_busy", 32'(busy), 0);
        chk("async_cycles", cycles, 0);
        chk("async_n_blocks", sd_if.sdspi_n_blocks, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        chk("sb_empty", 32'(sb_q.size()), 0);
        chk("done_count", 32'(n_done), 32'(n_pushed));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
